// File: rtl/toy_bus_slv_node_resp_pkg.sv
// Shared toy bus definitions: field widths, opcode encoding and the tag
// record a slave node keeps for each outstanding request.
package toy_bus_slv_node_resp_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int STRB_W = 32;
    localparam int ID_W   = 4;
    localparam int SB_W   = 10;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } opcode_e;

    // What the node must remember to build the ack once the slave answers.
    typedef struct packed {
        logic [ID_W-1:0] src_id;
        logic [SB_W-1:0] sideband;
        opcode_e         opcode;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/toy_bus_slv_node_resp_if.sv
// Toy bus slave-node interface: network request in, slave request out,
// slave ack in, network ack out.
//   slave  modport : the node's view (drives rdy on inputs, vld/payload on outputs)
//   master modport : the surrounding fabric/memory view
interface toy_bus_slv_node_resp_if;
    import toy_bus_slv_node_resp_pkg::*;

    logic              in_req_vld;
    logic              in_req_rdy;
    logic [ADDR_W-1:0] in_req_addr;
    logic [DATA_W-1:0] in_req_data;
    logic [STRB_W-1:0] in_req_strb;
    logic              in_req_opcode;
    logic [ID_W-1:0]   in_req_src_id;
    logic [ID_W-1:0]   in_req_tgt_id;
    logic [SB_W-1:0]   in_req_sideband;

    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [STRB_W-1:0] mem_req_strb;
    logic              mem_req_opcode;

    logic              mem_ack_vld;
    logic              mem_ack_rdy;
    logic [DATA_W-1:0] mem_ack_data;

    logic              out_ack_vld;
    logic              out_ack_rdy;
    logic              out_ack_opcode;
    logic [DATA_W-1:0] out_ack_data;
    logic [SB_W-1:0]   out_ack_sideband;
    logic [ID_W-1:0]   out_ack_src_id;
    logic [ID_W-1:0]   out_ack_tgt_id;

    modport slave (
        input  in_req_vld, in_req_addr, in_req_data, in_req_strb, in_req_opcode,
               in_req_src_id, in_req_tgt_id, in_req_sideband,
        output in_req_rdy,
        output mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode,
        input  mem_req_rdy,
        input  mem_ack_vld, mem_ack_data,
        output mem_ack_rdy,
        output out_ack_vld, out_ack_opcode, out_ack_data, out_ack_sideband,
               out_ack_src_id, out_ack_tgt_id,
        input  out_ack_rdy
    );

    modport master (
        output in_req_vld, in_req_addr, in_req_data, in_req_strb, in_req_opcode,
               in_req_src_id, in_req_tgt_id, in_req_sideband,
        input  in_req_rdy,
        input  mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode,
        output mem_req_rdy,
        output mem_ack_vld, mem_ack_data,
        input  mem_ack_rdy,
        input  out_ack_vld, out_ack_opcode, out_ack_data, out_ack_sideband,
               out_ack_src_id, out_ack_tgt_id,
        output out_ack_rdy
    );

endinterface

// File: rtl/toy_bus_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, show-ahead read.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write (caller guarantees ~full)
//   pop, pop_data   : read of head (caller guarantees ~empty)
//   full, empty     : from the registered occupancy count only
module toy_bus_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);

endmodule

// File: rtl/toy_bus_slv_node_resp.sv
// Toy bus slave node, response side. Forwards requests addressed to this
// node to a local slave, remembers who asked in a tag FIFO, and turns the
// slave's in-order acks into network acks routed back to the initiator.
// Requests for other nodes are swallowed and flagged on err_misroute.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : in_req / mem_req / mem_ack / out_ack channels (slave modport)
//   err_misroute : one-cycle pulse the cycle after a misrouted request is dropped
module toy_bus_slv_node_resp
    import toy_bus_slv_node_resp_pkg::*;
#(
    parameter logic [ID_W-1:0] NODE_ID = 4'd2,
    parameter int              DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    toy_bus_slv_node_resp_if.slave  bus,
    output logic                    err_misroute
);
    logic matched, full, empty, mem_fire, ack_fire;
    tag_t push_tag, pop_tag;

    logic              ack_buf_vld;
    tag_t              ack_buf_tag;
    logic [DATA_W-1:0] ack_buf_data;

    // Request path: payload passes straight through, only vld/rdy are gated.
    assign matched            = (bus.in_req_tgt_id == NODE_ID);
    assign bus.mem_req_addr   = bus.in_req_addr;
    assign bus.mem_req_data   = bus.in_req_data;
    assign bus.mem_req_strb   = bus.in_req_strb;
    assign bus.mem_req_opcode = bus.in_req_opcode;
    assign bus.mem_req_vld    = bus.in_req_vld & matched & ~full;
    // Misrouted requests are always taken so they cannot block the network.
    assign bus.in_req_rdy     = matched ? (bus.mem_req_rdy & ~full) : 1'b1;
    assign mem_fire           = bus.mem_req_vld & bus.mem_req_rdy;

    assign push_tag = '{src_id:   bus.in_req_src_id,
                        sideband: bus.in_req_sideband,
                        opcode:   opcode_e'(bus.in_req_opcode)};

    toy_bus_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_fire),
        .push_data (push_tag),
        .pop       (ack_fire),
        .pop_data  (pop_tag),
        .full      (full),
        .empty     (empty)
    );

    // Ack path: a slave ack is only taken when a tag is waiting for it and
    // the one-entry ack buffer is free or draining this cycle.
    assign bus.mem_ack_rdy = ~empty & (~ack_buf_vld | bus.out_ack_rdy);
    assign ack_fire        = bus.mem_ack_vld & bus.mem_ack_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_buf_vld  <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            err_misroute <= bus.in_req_vld & ~matched;
            if (ack_fire)             ack_buf_vld <= 1'b1;
            else if (bus.out_ack_rdy) ack_buf_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ack_fire) begin
            ack_buf_tag  <= pop_tag;
            ack_buf_data <= bus.mem_ack_data;
        end
    end

    assign bus.out_ack_vld      = ack_buf_vld;
    assign bus.out_ack_opcode   = ack_buf_tag.opcode;
    assign bus.out_ack_sideband = ack_buf_tag.sideband;
    assign bus.out_ack_tgt_id   = ack_buf_tag.src_id;
    assign bus.out_ack_src_id   = NODE_ID;
    assign bus.out_ack_data     = ack_buf_data;

endmodule

// File: tb/tb_toy_bus_slv_node_resp.sv
module tb_toy_bus_slv_node_resp;
    import toy_bus_slv_node_resp_pkg::*;

    localparam logic [3:0] NODE_ID = 4'd2;
    localparam int         DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_misroute;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    toy_bus_slv_node_resp_if bus ();

    toy_bus_slv_node_resp #(.NODE_ID(NODE_ID), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .err_misroute (err_misroute)
    );

    // Reference model: tags outstanding at the slave, acks owed to the network.
    typedef struct { logic [3:0] src; logic [9:0] sb; logic op; } tag_m_t;
    typedef struct { logic [3:0] tgt; logic [9:0] sb; logic op; logic [255:0] data; } ack_m_t;
    tag_m_t tagq[$];
    ack_m_t expq[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic   prev_mis;
    logic   m_match, m_full;
    tag_m_t t_pop;
    ack_m_t a_exp;

    always @(negedge clk) begin
        if (rst) begin
            tagq.delete();
            expq.delete();
            prev_mis = 1'b0;
        end else begin
            m_match = (bus.in_req_tgt_id == NODE_ID);
            m_full  = (tagq.size() >= DEPTH);
            chk("err_misroute", 256'(err_misroute), 256'(prev_mis));
            chk("in_req_rdy", 256'(bus.in_req_rdy),
                256'(m_match ? (bus.mem_req_rdy && !m_full) : 1'b1));
            chk("mem_req_vld", 256'(bus.mem_req_vld),
                256'(bus.in_req_vld && m_match && !m_full));
            if (bus.mem_req_vld) begin
                chk("mem_req_ctl", 256'({bus.mem_req_addr, bus.mem_req_strb, bus.mem_req_opcode}),
                    256'({bus.in_req_addr, bus.in_req_strb, bus.in_req_opcode}));
                chk("mem_req_data", bus.mem_req_data, bus.in_req_data);
            end
            chk("mem_ack_rdy", 256'(bus.mem_ack_rdy),
                256'(tagq.size() != 0 && (expq.size() == 0 || bus.out_ack_rdy)));
            chk("out_ack_vld", 256'(bus.out_ack_vld), 256'(expq.size() != 0));
            if (bus.out_ack_vld && expq.size() != 0) begin
                chk("out_ack_hdr",
                    256'({bus.out_ack_tgt_id, bus.out_ack_src_id, bus.out_ack_sideband, bus.out_ack_opcode}),
                    256'({expq[0].tgt, NODE_ID, expq[0].sb, expq[0].op}));
                chk("out_ack_data", bus.out_ack_data, expq[0].data);
            end
            // Update model with this cycle's handshakes.
            if (bus.out_ack_vld && bus.out_ack_rdy && expq.size() != 0) void'(expq.pop_front());
            if (bus.mem_ack_vld && bus.mem_ack_rdy) begin
                if (tagq.size() == 0) chk("ack_without_tag", 256'(1), 256'(0));
                else begin
                    t_pop = tagq.pop_front();
                    a_exp = '{tgt: t_pop.src, sb: t_pop.sb, op: t_pop.op, data: bus.mem_ack_data};
                    expq.push_back(a_exp);
                end
            end
            if (bus.in_req_vld && bus.in_req_rdy && m_match)
                tagq.push_back('{src: bus.in_req_src_id, sb: bus.in_req_sideband, op: bus.in_req_opcode});
            prev_mis = bus.in_req_vld && !m_match;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] src, input logic [3:0] tgt,
                           input logic [9:0] sb, input logic op);
        bus.in_req_vld      = 1'b1;
        bus.in_req_src_id   = src;
        bus.in_req_tgt_id   = tgt;
        bus.in_req_sideband = sb;
        bus.in_req_opcode   = op;
        bus.in_req_addr     = $urandom;
        bus.in_req_strb     = $urandom;
        bus.in_req_data     = rand256();
    endtask

    task automatic send_req(input logic [3:0] src, input logic [3:0] tgt,
                            input logic [9:0] sb, input logic op);
        logic done;
        done = 1'b0;
        set_req(src, tgt, sb, op);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = bus.in_req_rdy;
            tick();
        end
        bus.in_req_vld = 1'b0;
        if (!done) chk("req_timeout", 256'(done), 256'(1));
    endtask

    task automatic send_rand();
        send_req(4'($urandom), NODE_ID, 10'($urandom), 1'($urandom));
    endtask

    task automatic mem_ack_one(input logic [255:0] d);
        logic done;
        done = 1'b0;
        bus.mem_ack_vld  = 1'b1;
        bus.mem_ack_data = d;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = bus.mem_ack_rdy;
            tick();
        end
        bus.mem_ack_vld = 1'b0;
        if (!done) chk("ack_timeout", 256'(done), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_req_vld = 1'b0; bus.in_req_addr = '0; bus.in_req_data = '0;
        bus.in_req_strb = '0; bus.in_req_opcode = 1'b0; bus.in_req_src_id = '0;
        bus.in_req_tgt_id = NODE_ID; bus.in_req_sideband = '0;
        bus.mem_req_rdy = 1'b1; bus.mem_ack_vld = 1'b0; bus.mem_ack_data = '0;
        bus.out_ack_rdy = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_out_ack_vld", 256'(bus.out_ack_vld), 256'(0));
        chk("rst_err",         256'(err_misroute),    256'(0));
        chk("rst_mem_ack_rdy", 256'(bus.mem_ack_rdy), 256'(0));
        chk("rst_in_req_rdy",  256'(bus.in_req_rdy),  256'(1));
        tick();
        rst = 1'b0;
        tick();

        // Basic read: ack one cycle after the slave ack, routed back to src 0
        send_req(4'd0, NODE_ID, 10'h15, logic'(OP_READ));
        bus.mem_ack_vld  = 1'b1;
        bus.mem_ack_data = 256'hAB;
        @(negedge clk);
        chk("rd_mem_ack_rdy", 256'(bus.mem_ack_rdy), 256'(1));
        tick();
        bus.mem_ack_vld = 1'b0;
        @(negedge clk);
        chk("rd_out_vld",  256'(bus.out_ack_vld), 256'(1));
        chk("rd_out_data", bus.out_ack_data, 256'hAB);
        chk("rd_out_ids",  256'({bus.out_ack_tgt_id, bus.out_ack_src_id, bus.out_ack_sideband}),
            256'({4'd0, 4'd2, 10'h15}));
        tick();

        // Fill: 4 outstanding blocks the 5th until an ack pops a tag
        repeat (4) send_rand();
        set_req(4'd7, NODE_ID, 10'h3C5, 1'b1);
        @(negedge clk);
        chk("fill_in_req_rdy",  256'(bus.in_req_rdy),  256'(0));
        chk("fill_mem_req_vld", 256'(bus.mem_req_vld), 256'(0));
        tick();
        bus.mem_ack_vld  = 1'b1;
        bus.mem_ack_data = rand256();
        @(negedge clk);
        chk("fill_pop_rdy",      256'(bus.mem_ack_rdy), 256'(1));
        chk("fill_same_cyc_rdy", 256'(bus.in_req_rdy),  256'(0));
        tick();
        bus.mem_ack_vld = 1'b0;
        @(negedge clk);
        chk("fill_freed_rdy", 256'(bus.in_req_rdy), 256'(1));
        tick();
        bus.in_req_vld = 1'b0;
        repeat (4) mem_ack_one(rand256());
        tick();

        // Backpressure: held ack blocks further slave acks, order kept
        bus.out_ack_rdy = 1'b0;
        repeat (3) send_rand();
        mem_ack_one(rand256());
        bus.mem_ack_vld  = 1'b1;
        bus.mem_ack_data = rand256();
        repeat (3) begin
            @(negedge clk);
            chk("bp_mem_ack_rdy", 256'(bus.mem_ack_rdy), 256'(0));
            chk("bp_out_vld",     256'(bus.out_ack_vld), 256'(1));
            tick();
        end
        bus.mem_ack_vld = 1'b0;
        bus.out_ack_rdy = 1'b1;
        mem_ack_one(rand256());
        mem_ack_one(rand256());
        tick(); tick();

        // Misroute: taken, not forwarded, one error pulse, nothing queued
        set_req(4'd1, 4'd3, 10'h2A, 1'b1);
        @(negedge clk);
        chk("mis_in_req_rdy",  256'(bus.in_req_rdy),  256'(1));
        chk("mis_mem_req_vld", 256'(bus.mem_req_vld), 256'(0));
        tick();
        bus.in_req_vld  = 1'b0;
        bus.mem_ack_vld = 1'b1;
        @(negedge clk);
        chk("mis_err_pulse",   256'(err_misroute),    256'(1));
        chk("mis_no_tag",      256'(bus.mem_ack_rdy), 256'(0));
        tick();
        bus.mem_ack_vld = 1'b0;
        @(negedge clk);
        chk("mis_err_once", 256'(err_misroute), 256'(0));
        tick();

        // Reset with traffic in flight
        bus.out_ack_rdy = 1'b0;
        repeat (3) send_rand();
        mem_ack_one(rand256());
        @(negedge clk);
        chk("pre_rst_out_vld", 256'(bus.out_ack_vld), 256'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ack_vld = 1'b1;
        @(negedge clk);
        chk("post_rst_out_vld", 256'(bus.out_ack_vld), 256'(0));
        chk("post_rst_stale",   256'(bus.mem_ack_rdy), 256'(0));
        tick();
        @(negedge clk);
        chk("post_rst_out_vld2", 256'(bus.out_ack_vld), 256'(0));
        bus.mem_ack_vld = 1'b0;
        bus.out_ack_rdy = 1'b1;
        tick();

        // Random traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.in_req_vld      = 1'($urandom);
            bus.in_req_tgt_id   = ($urandom_range(0, 7) == 0) ? (NODE_ID ^ 4'($urandom_range(1, 15))) : NODE_ID;
            bus.in_req_src_id   = 4'($urandom);
            bus.in_req_sideband = 10'($urandom);
            bus.in_req_opcode   = 1'($urandom);
            bus.in_req_addr     = $urandom;
            bus.in_req_strb     = $urandom;
            bus.in_req_data     = rand256();
            bus.mem_req_rdy     = ($urandom_range(0, 3) != 0);
            bus.mem_ack_vld     = 1'($urandom);
            bus.mem_ack_data    = rand256();
            bus.out_ack_rdy     = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain everything still owed
        bus.in_req_vld  = 1'b0;
        bus.out_ack_rdy = 1'b1;
        bus.mem_ack_vld = 1'b1;
        for (int c = 0; c < 200 && (tagq.size() != 0 || expq.size() != 0); c++) begin
            bus.mem_ack_data = rand256();
            tick();
        end
        bus.mem_ack_vld = 1'b0;
        chk("drain_tags", 256'(tagq.size()), 256'(0));
        chk("drain_acks", 256'(expq.size()), 256'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toy_bus_slv_node_resp.md
TOY_BUS_SLV_NODE_RESP -- requirements
Module: toy_bus_slv_node_resp

Interface
REQ-001 SHALL have parameter NODE_ID, default 4'd2: this node's bus ID.
REQ-002 SHALL have parameter DEPTH, default 4: max outstanding requests (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_req_vld / in_req_rdy  in / out  1 each  network request handshake.
REQ-006 SHALL have port in_req_addr  in  32  request address.
REQ-007 SHALL have port in_req_data / in_req_strb  in  256 / 32  write data and byte strobes.
REQ-008 SHALL have port in_req_opcode  in  1  0 = read, 1 = write.
REQ-009 SHALL have port in_req_src_id / in_req_tgt_id  in  4 each  initiator and target IDs.
REQ-010 SHALL have port in_req_sideband  in  10  opaque initiator tag.
REQ-011 SHALL have port mem_req_vld / mem_req_rdy  out / in  1 each  slave request handshake.
REQ-012 SHALL have port mem_req_addr / mem_req_data / mem_req_strb / mem_req_opcode  out  32/256/32/1  request payload to the slave.
REQ-013 SHALL have port mem_ack_vld / mem_ack_rdy  in / out  1 each  slave response handshake; responses return in order.
REQ-014 SHALL have port mem_ack_data  in  256  slave response data.
REQ-015 SHALL have port out_ack_vld / out_ack_rdy  out / in  1 each  network ack handshake.
REQ-016 SHALL have port out_ack_opcode / out_ack_data / out_ack_sideband  out  1/256/10  ack payload.
REQ-017 SHALL have port out_ack_src_id / out_ack_tgt_id  out  4 each  responder and return-destination IDs.
REQ-018 SHALL have port err_misroute  out  1  one-cycle pulse per dropped misrouted request.

Function
REQ-019 SHALL pass in_req addr/data/strb/opcode combinationally to mem_req_*.
REQ-020 SHALL treat a request as matched when in_req_tgt_id == NODE_ID; mem_req_vld = in_req_vld & matched & ~full; for matched requests in_req_rdy = mem_req_rdy & ~full.
REQ-021 SHALL accept misrouted requests (in_req_rdy = 1), keep them off the mem side, push nothing, and assert err_misroute the following cycle.
REQ-022 SHALL push {src_id, sideband, opcode} into a DEPTH-entry tag FIFO on every mem_req fire.
REQ-023 SHALL derive full from the registered count only; a pop in the same cycle does not free a slot for a push.
REQ-024 SHALL drive mem_ack_rdy = ~empty & (~ack_buf_vld | out_ack_rdy); mem_ack_vld while empty is never accepted.
REQ-025 SHALL, on mem_ack fire, pop the FIFO head and load a one-entry ack register in the same edge; latency from mem_ack fire to out_ack_vld is 1 cycle.
REQ-026 SHALL drive out_ack_tgt_id = stored src_id, out_ack_src_id = NODE_ID, out_ack_sideband and opcode from the popped entry, and out_ack_data = mem_ack_data captured.
REQ-027 SHALL hold out_ack_vld and its payload stable until out_ack_rdy; load and drain in one cycle sustains 1 ack/cycle.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH, and sustain push and pop in the same cycle when neither full nor empty.

Reset
REQ-029 SHALL, on rst, clear FIFO pointers and count, ack_buf_vld, out_ack_vld, and err_misroute to 0, dropping in-flight tags; in_req_rdy and mem_req_vld follow from the empty state the next cycle.

Structure
REQ-030 SHALL take field widths (addr 32, data 256, strb 32, id 4, sideband 10) and opcode encodings from the shared toy_bus package.
REQ-031 SHALL instantiate the tag FIFO as sub-module toy_bus_sync_fifo (parameterised width/depth).

Verification
REQ-032 Read: src 0, tgt 2, sideband 0x15, mem acks 1 cycle later with data 0xAB -> out_ack_tgt 0, src 2, sideband 0x15, data 0xAB, one cycle after mem ack.
REQ-033 Fill: 4 requests with no mem acks -> in_req_rdy low on the 5th; the first ack frees the slot one cycle later.
REQ-034 Backpressure: out_ack_rdy low with 3 acks pending -> mem_ack_rdy low, out_ack payload held, order preserved after release.
REQ-035 Misroute: tgt_id 3 -> accepted, mem_req_vld stays 0, err_misroute pulses once, FIFO count unchanged.
REQ-036 Reset mid-traffic: rst with 2 outstanding -> out_ack_vld 0 and count 0 next cycle; stale mem_ack ignored.
